leela_sprite_engine: RTL

- Parametrised successor to the fixed-pattern overlay sprite ROM in the Leela video path.
- Sprite bitmaps live in a CPU-writable synchronous RAM holding NFRAMES frames of SPR_H rows x SPR_W bits; position, frame and enable are shadow-buffered and take effect at frame start.
- Per raster line the block fetches one row into a shift register and streams a 1-bit overlay mask aligned to the pixel strobe.
- Sits between the Leela register interface and the VGA pixel mux.

---
 rtl/leela_sprite_pkg.sv | 26 ++
 rtl/leela_sprite_ram.sv | 29 ++
 rtl/leela_sprite_engine.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/leela_sprite_pkg.sv
// Shared constants, fetch FSM encoding and address-width helper for the
// Leela sprite engine. Optional row mirroring is enabled by defining
// LEELA_SPRITE_MIRROR_EN (see leela_sprite_engine).
package leela_sprite_pkg;

  localparam int SPR_W_DEF   = 32;
  localparam int SPR_H_DEF   = 32;
  localparam int NFRAMES_DEF = 2;
  localparam int POS_W_DEF   = 11;

  // Per-line row fetch sequence.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    READ = 2'd2,
    LOAD = 2'd3
  } fetch_state_t;

  // Address width of the sprite RAM; never less than one bit.
  function automatic int calc_aw(input int nframes, input int spr_h);
    int depth;
    depth = nframes * spr_h;
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/leela_sprite_ram.sv
// One write port, one read port synchronous RAM with registered output.
// A same-cycle read of the address being written returns the old data.
// Contents are not reset.
module leela_sprite_ram #(
  parameter int DW    = 32,
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_adr,
  input  logic [DW-1:0] wr_dat,
  input  logic [AW-1:0] rd_adr,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[wr_adr] <= wr_dat;
  end

  // Registered read port; sees the pre-write contents on a collision.
  always_ff @(posedge clk) begin
    rd_dat <= mem[rd_adr];
  end

endmodule

// File: rtl/leela_sprite_engine.sv
// Leela sprite engine: CPU-written sprite RAM, frame-synchronous position
// shadowing, one row fetched per raster line and streamed as a 1-bit
// overlay mask on the pixel strobe.
// Optional feature macro: LEELA_SPRITE_MIRROR_EN adds mirror_i, which shows
// the row LSB first when active.
// Strobe semantics: pix_en_i is a single-cycle qualifier with no back
// pressure; each high cycle consumes one pixel and pix_o for that pixel is
// valid the following cycle and held until the next strobe.
module leela_sprite_engine
  import leela_sprite_pkg::*;
#(
  parameter int SPR_W   = SPR_W_DEF,
  parameter int SPR_H   = SPR_H_DEF,
  parameter int NFRAMES = NFRAMES_DEF,
  parameter int POS_W   = POS_W_DEF,
  localparam int AW     = calc_aw(NFRAMES, SPR_H),
  localparam int FW     = (NFRAMES > 1) ? $clog2(NFRAMES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_we,
  input  logic [AW-1:0]    mem_adr,
  input  logic [SPR_W-1:0] mem_dat,
  input  logic             pos_we,
  input  logic [POS_W-1:0] pos_x,
  input  logic [POS_W-1:0] pos_y,
  input  logic [FW-1:0]    frame_sel,
  input  logic             spr_en,
`ifdef LEELA_SPRITE_MIRROR_EN
  input  logic             mirror_i,
`endif
  input  logic             frame_start_i,
  input  logic             line_start_i,
  input  logic             pix_en_i,
  output logic             pix_o,
  output logic             row_hit_o,
  output fetch_state_t     dbg_state
);

  localparam int CW = $clog2(SPR_W + 1);

  logic [POS_W-1:0] sh_x, sh_y, act_x, act_y;
  logic [FW-1:0]    sh_frame, act_frame;
  logic             sh_en, act_en;

  logic [POS_W-1:0] line_cnt, pix_cnt, pix_cnt_inc;
  logic [POS_W-1:0] row;
  logic             row_hit_d, hit_q;
  logic [AW-1:0]    calc_adr;
  logic [SPR_W-1:0] ram_q, load_data, shreg;
  logic [CW-1:0]    col;
  logic             shift_go;

  fetch_state_t     state_q, state_d;
  logic             calc_en, load_en;

  assign dbg_state = state_q;

  // Shadow registers take CPU writes; active copies change only at frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_x      <= '0;
      sh_y      <= '0;
      sh_frame  <= '0;
      sh_en     <= 1'b0;
      act_x     <= '0;
      act_y     <= '0;
      act_frame <= '0;
      act_en    <= 1'b0;
    end else begin
      if (pos_we) begin
        sh_x     <= pos_x;
        sh_y     <= pos_y;
        sh_frame <= frame_sel;
        sh_en    <= spr_en;
      end
      if (frame_start_i) begin
        act_x     <= pos_we ? pos_x     : sh_x;
        act_y     <= pos_we ? pos_y     : sh_y;
        act_frame <= pos_we ? frame_sel : sh_frame;
        act_en    <= pos_we ? spr_en    : sh_en;
      end
    end
  end

`ifdef LEELA_SPRITE_MIRROR_EN
  logic sh_mir, act_mir;

  // Mirror bit follows the same shadow/active path as the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_mir  <= 1'b0;
      act_mir <= 1'b0;
    end else begin
      if (pos_we) sh_mir <= mirror_i;
      if (frame_start_i) act_mir <= pos_we ? mirror_i : sh_mir;
    end
  end
`endif

  // Raster counters: all-ones start so the first strobe/line lands on 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_cnt <= '1;
      pix_cnt  <= '1;
    end else begin
      if (frame_start_i)     line_cnt <= '1;
      else if (line_start_i) line_cnt <= line_cnt + POS_W'(1);
      if (line_start_i)      pix_cnt  <= '1;
      else if (pix_en_i)     pix_cnt  <= pix_cnt_inc;
    end
  end

  assign pix_cnt_inc = pix_cnt + POS_W'(1);

  // Row select for the current line; lines above the sprite wrap to a large row.
  always_comb begin
    row       = line_cnt - act_y;
    row_hit_d = act_en && (32'(row) < 32'(SPR_H));
    calc_adr  = AW'(32'(act_frame) * 32'(SPR_H) + 32'(row));
  end

  leela_sprite_ram #(
    .DW    (SPR_W),
    .AW    (AW),
    .DEPTH (NFRAMES * SPR_H)
  ) u_ram (
    .clk    (clk),
    .we     (mem_we),
    .wr_adr (mem_adr),
    .wr_dat (mem_dat),
    .rd_adr (calc_adr),
    .rd_dat (ram_q)
  );

  // Row word as it enters the shift register (optionally bit-reversed).
  always_comb begin
    load_data = ram_q;
`ifdef LEELA_SPRITE_MIRROR_EN
    if (act_mir) begin
      for (int i = 0; i < SPR_W; i++) load_data[i] = ram_q[SPR_W-1-i];
    end
`endif
  end

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Fetch FSM next state; a new line always restarts the fetch.
  always_comb begin
    state_d = state_q;
    calc_en = 1'b0;
    load_en = 1'b0;
    if (line_start_i) begin
      state_d = CALC;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        CALC: begin
          state_d = READ;
          calc_en = 1'b1;
        end
        READ: state_d = LOAD;
        LOAD: begin
          state_d = IDLE;
          load_en = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Shift starts when the strobe reaches act_x and runs for SPR_W strobes.
  assign shift_go = ((col != '0) || (pix_cnt_inc == act_x)) && (col < CW'(SPR_W));

  // Row load at end of fetch, then one bit out per strobe inside the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q     <= 1'b0;
      shreg     <= '0;
      col       <= '0;
      pix_o     <= 1'b0;
      row_hit_o <= 1'b0;
    end else begin
      if (calc_en) hit_q <= row_hit_d;
      if (line_start_i) begin
        pix_o <= 1'b0;
      end else if (load_en) begin
        shreg     <= hit_q ? load_data : '0;
        row_hit_o <= hit_q;
        col       <= '0;
      end else if (pix_en_i) begin
        if (shift_go) begin
          pix_o <= shreg[SPR_W-1] & row_hit_o;
          shreg <= shreg << 1;
          col   <= col + CW'(1);
        end else begin
          pix_o <= 1'b0;
        end
      end
    end
  end

endmodule
